// File: rtl/spi_slave_shifter_pkg.sv
// Shared types and defaults for the SPI responder shifter.
package spi_slave_shifter_pkg;

  // Responder FSM: IDLE waits for slave select, SHIFT moves bits.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam int DATA_W_DEF = 8;
  localparam int SYNC_DEF   = 2;

  // Idle level of the pin synchronizers: ss idles high, sclk/mosi low.
  localparam logic SS_IDLE   = 1'b1;
  localparam logic SCLK_IDLE = 1'b0;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin, with one-cycle
// rise/fall pulses derived from the synchronized value.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  // Shift the pin through the synchronizer and remember the last synced value.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= {STAGES{RST_VAL}};
      r_prev <= RST_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_rise =  r_sync[STAGES-1] & ~r_prev;
  assign o_fall = ~r_sync[STAGES-1] &  r_prev;

endmodule

// File: rtl/spi_slave_shifter.sv
// SPI responder: oversamples sclk/ss/mosi in PCLK, shifts rx bits into
// rx_data_o and drives miso_o from a one-entry transmit holding buffer.
module spi_slave_shifter
  import spi_slave_shifter_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = SYNC_DEF
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              spe_i,
  input  logic              cpol_i,
  input  logic              cpha_i,
  input  logic              lsbfe_i,
  input  logic              sclk_i,
  input  logic              ss_i,
  input  logic              mosi_i,
  output logic              miso_o,
  output logic              miso_oe_o,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i,
  output logic              busy_o,
  output logic              overrun_o,
  output logic              underrun_o,
  output logic              abort_o
);

  localparam int                CNT_W    = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);

  // Bit currently presented on the wire for a given shifter image.
  function automatic logic f_pick(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? v[0] : v[DATA_W-1];
  endfunction

  // Shifter image after the presented bit has been consumed.
  function automatic logic [DATA_W-1:0] f_adv(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? (v >> 1) : (v << 1);
  endfunction

  logic w_sclk_rise, w_sclk_fall, w_ss_rise, w_ss_fall;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic w_mosi;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(SCLK_IDLE)) u_sclk_sync (
    .i_clk (PCLK),
    .i_rst (PRESET),
    .i_d   (sclk_i),
    .o_rise(w_sclk_rise),
    .o_fall(w_sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(SS_IDLE)) u_ss_sync (
    .i_clk (PCLK),
    .i_rst (PRESET),
    .i_d   (ss_i),
    .o_rise(w_ss_rise),
    .o_fall(w_ss_fall)
  );

  // mosi only needs synchronizing; it is sampled on sclk edges.
  always_ff @(posedge PCLK) begin
    if (PRESET) r_mosi_sync <= '0;
    else        r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi_i};
  end
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

  state_e r_state, w_next_state;
  logic   r_cpol, r_cpha, r_lsbfe;
  logic [CNT_W-1:0]  r_bitcnt;
  logic [DATA_W-1:0] r_tx_sh, r_rx_sh, r_buf;
  logic              r_buf_full;

  logic w_lead, w_trail;
  logic w_start, w_exit, w_abort, w_sample, w_shift_out, w_reload;
  logic w_boundary, w_load, w_load_cpha, w_load_lsb;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic [DATA_W-1:0] w_rx_next, w_load_byte;

  // Leading edge leaves the latched idle level, trailing edge returns to it.
  assign w_lead  = r_cpol ? w_sclk_fall : w_sclk_rise;
  assign w_trail = r_cpol ? w_sclk_rise : w_sclk_fall;

  // State register.
  always_ff @(posedge PCLK) begin
    if (PRESET) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Next state and per-cycle actions; spe drop beats ss rise beats sclk edges.
  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_exit       = 1'b0;
    w_abort      = 1'b0;
    w_sample     = 1'b0;
    w_shift_out  = 1'b0;
    w_reload     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (spe_i && w_ss_fall) begin
          w_start      = 1'b1;
          w_next_state = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (!spe_i) begin
          w_exit       = 1'b1;
          w_next_state = ST_IDLE;
        end else if (w_ss_rise) begin
          w_exit       = 1'b1;
          w_abort      = (r_bitcnt != '0);
          w_next_state = ST_IDLE;
        end else if (w_lead) begin
          if (r_cpha) w_shift_out = 1'b1;
          else        w_sample    = 1'b1;
        end else if (w_trail) begin
          if (r_cpha)                w_sample    = 1'b1;
          else if (r_bitcnt == '0)   w_reload    = 1'b1;
          else                       w_shift_out = 1'b1;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  assign w_cnt_inc   = r_bitcnt + CNT_W'(1);
  assign w_boundary  = w_sample && (w_cnt_inc == CNT_LAST);
  // CPHA=1 reloads right at the byte boundary; CPHA=0 waits for the trailing edge.
  assign w_load      = w_start | w_reload | (w_boundary & r_cpha);
  assign w_load_cpha = w_start ? cpha_i  : r_cpha;
  assign w_load_lsb  = w_start ? lsbfe_i : r_lsbfe;
  assign w_load_byte = r_buf_full ? r_buf : '0;
  assign w_rx_next   = r_lsbfe ? {w_mosi, r_rx_sh[DATA_W-1:1]}
                               : {r_rx_sh[DATA_W-2:0], w_mosi};

  // Datapath: mode latch, bit counter, rx/tx shifters, holding buffer, pulses.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_cpol     <= 1'b0;
      r_cpha     <= 1'b0;
      r_lsbfe    <= 1'b0;
      r_bitcnt   <= '0;
      r_tx_sh    <= '0;
      r_rx_sh    <= '0;
      r_buf      <= '0;
      r_buf_full <= 1'b0;
      miso_o     <= 1'b0;
      rx_data_o  <= '0;
      rx_valid_o <= 1'b0;
      overrun_o  <= 1'b0;
      underrun_o <= 1'b0;
      abort_o    <= 1'b0;
    end else begin
      overrun_o  <= 1'b0;
      underrun_o <= 1'b0;
      abort_o    <= w_abort;

      if (w_start) begin
        r_cpol     <= cpol_i;
        r_cpha     <= cpha_i;
        r_lsbfe    <= lsbfe_i;
        underrun_o <= ~r_buf_full;
      end

      if (w_start || w_exit)                r_bitcnt <= '0;
      else if (w_sample)                    r_bitcnt <= w_boundary ? '0 : w_cnt_inc;

      if (w_start || w_exit)                r_rx_sh <= '0;
      else if (w_sample)                    r_rx_sh <= w_rx_next;

      // A completion in the same cycle as an accept keeps rx_valid_o high.
      if (w_boundary) begin
        rx_data_o  <= w_rx_next;
        rx_valid_o <= 1'b1;
        overrun_o  <= rx_valid_o & ~rx_ready_i;
      end else if (rx_ready_i) begin
        rx_valid_o <= 1'b0;
      end

      // CPHA=0 presents bit0 at load; CPHA=1 waits for the first leading edge.
      if (w_load) begin
        if (!w_load_cpha) begin
          miso_o  <= f_pick(w_load_byte, w_load_lsb);
          r_tx_sh <= f_adv(w_load_byte, w_load_lsb);
        end else begin
          r_tx_sh <= w_load_byte;
        end
      end else if (w_shift_out) begin
        miso_o  <= f_pick(r_tx_sh, r_lsbfe);
        r_tx_sh <= f_adv(r_tx_sh, r_lsbfe);
      end
      if (w_exit) miso_o <= 1'b0;

      // A write into an empty buffer lands after any load that empties it.
      if (w_load) r_buf_full <= 1'b0;
      if (tx_valid_i && !r_buf_full) begin
        r_buf      <= tx_data_i;
        r_buf_full <= 1'b1;
      end
    end
  end

  assign tx_ready_o = ~r_buf_full;
  assign busy_o     = (r_state == ST_SHIFT);
  assign miso_oe_o  = (r_state == ST_SHIFT);

endmodule

// File: tb/tb_spi_slave_shifter.sv
// Bench for spi_slave_shifter: a behavioural SPI master drives random and
// directed frames; expectations come from the bytes queued and sent.
module tb_spi_slave_shifter;

  localparam int HALF = 6;

  logic       PCLK = 1'b0;
  logic       PRESET, spe_i, cpol_i, cpha_i, lsbfe_i;
  logic       sclk_i, ss_i, mosi_i, miso_o, miso_oe_o;
  logic [7:0] tx_data_i, rx_data_o;
  logic       tx_valid_i, tx_ready_o, rx_valid_o, rx_ready_i;
  logic       busy_o, overrun_o, underrun_o, abort_o;

  int total = 0;
  int bad   = 0;
  int n_ovr = 0, n_und = 0, n_abt = 0;

  logic [7:0] m_out[4];   // bytes the master shifts out on mosi
  logic [7:0] m_in[4];    // bytes the master collects from miso
  logic [7:0] m_feed[4];  // bytes offered to the holding buffer
  logic [7:0] feed_q[$];

  spi_slave_shifter dut (
    .PCLK(PCLK), .PRESET(PRESET), .spe_i(spe_i), .cpol_i(cpol_i),
    .cpha_i(cpha_i), .lsbfe_i(lsbfe_i), .sclk_i(sclk_i), .ss_i(ss_i),
    .mosi_i(mosi_i), .miso_o(miso_o), .miso_oe_o(miso_oe_o),
    .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
    .busy_o(busy_o), .overrun_o(overrun_o), .underrun_o(underrun_o),
    .abort_o(abort_o)
  );

  always #5 PCLK = ~PCLK;

  // Pulse counters.
  initial forever begin
    @(negedge PCLK);
    if (overrun_o)  n_ovr++;
    if (underrun_o) n_und++;
    if (abort_o)    n_abt++;
  end

  // Holding-buffer feeder: offers the next queued byte whenever the buffer is empty.
  initial begin
    tx_valid_i = 1'b0;
    tx_data_i  = 8'h00;
    forever begin
      @(negedge PCLK);
      if (tx_valid_i) void'(feed_q.pop_front());
      tx_valid_i = 1'b0;
      if (feed_q.size() > 0 && tx_ready_o) begin
        tx_valid_i = 1'b1;
        tx_data_i  = feed_q[0];
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge PCLK);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".miso"},     32'(miso_o),     0);
    chk({tag, ".miso_oe"},  32'(miso_oe_o),  0);
    chk({tag, ".tx_ready"}, 32'(tx_ready_o), 1);
    chk({tag, ".rx_data"},  32'(rx_data_o),  0);
    chk({tag, ".rx_valid"}, 32'(rx_valid_o), 0);
    chk({tag, ".busy"},     32'(busy_o),     0);
    chk({tag, ".pulses"},   32'({overrun_o, underrun_o, abort_o}), 0);
  endtask

  function automatic logic bitof(input int k);
    logic [7:0] b;
    int j;
    b = m_out[k / 8];
    j = k % 8;
    return lsbfe_i ? b[j] : b[7 - j];
  endfunction

  // Behavioural master: nbits bits under ss; optional PRESET at bit rst_bit.
  task automatic frame(input int nbits, input int rst_bit);
    int j;
    for (int b = 0; b < 4; b++) m_in[b] = 8'h00;
    ss_i   = 1'b0;
    mosi_i = cpha_i ? 1'b0 : bitof(0);
    tick(8);
    for (int k = 0; k < nbits; k++) begin
      if (k == rst_bit) begin
        PRESET = 1'b1;
        tick(1);
        chk_reset("midreset");
        ss_i   = 1'b1;
        sclk_i = cpol_i;
        tick(4);
        PRESET = 1'b0;
        tick(4);
        return;
      end
      j = lsbfe_i ? (k % 8) : (7 - (k % 8));
      if (!cpha_i) begin
        m_in[k / 8][j] = miso_o;
        sclk_i = ~cpol_i;
        tick(HALF);
        sclk_i = cpol_i;
        if (k + 1 < nbits) mosi_i = bitof(k + 1);
        tick(HALF);
      end else begin
        sclk_i = ~cpol_i;
        mosi_i = bitof(k);
        tick(HALF);
        m_in[k / 8][j] = miso_o;
        sclk_i = cpol_i;
        tick(HALF);
      end
    end
    tick(4);
    ss_i = 1'b1;
    tick(8);
  endtask

  task automatic set_mode(input logic cp, input logic ph, input logic lb);
    cpol_i  = cp;
    cpha_i  = ph;
    lsbfe_i = lb;
    sclk_i  = cp;
    tick(4);
    rx_ready_i = 1'b1;
    tick(1);
    rx_ready_i = 1'b0;
  endtask

  // Full frame of nbytes with `avail` bytes queued; model: master sees queued
  // bytes in order then zeros, slave ends with the last mosi byte.
  task automatic do_case(input string tag, input logic cp, input logic ph,
                         input logic lb, input int nbytes, input int avail);
    int o0, u0, a0;
    logic [7:0] exp;
    set_mode(cp, ph, lb);
    for (int i = 0; i < avail; i++) feed_q.push_back(m_feed[i]);
    tick(4);
    o0 = n_ovr; u0 = n_und; a0 = n_abt;
    frame(nbytes * 8, -1);
    for (int b = 0; b < nbytes; b++) begin
      exp = (b < avail) ? m_feed[b] : 8'h00;
      chk($sformatf("%s.miso_byte%0d", tag, b), 32'(m_in[b]), 32'(exp));
    end
    chk({tag, ".rx_data"},  32'(rx_data_o), 32'(m_out[nbytes - 1]));
    chk({tag, ".rx_valid"}, 32'(rx_valid_o), 1);
    chk({tag, ".overrun"},  n_ovr - o0, nbytes - 1);
    chk({tag, ".underrun"}, n_und - u0, (avail == 0) ? 1 : 0);
    chk({tag, ".abort"},    n_abt - a0, 0);
    chk({tag, ".busy"},     32'(busy_o), 0);
    chk({tag, ".tx_ready"}, 32'(tx_ready_o), 1);
  endtask

  initial begin
    int nb, av, a0;
    PRESET = 1'b1; spe_i = 1'b1; cpol_i = 1'b0; cpha_i = 1'b0; lsbfe_i = 1'b0;
    sclk_i = 1'b0; ss_i = 1'b1; mosi_i = 1'b0; rx_ready_i = 1'b0;
    tick(3);
    chk_reset("reset");
    PRESET = 1'b0;
    tick(4);

    // Mode 0, MSB first.
    m_feed[0] = 8'hA5; m_out[0] = 8'h3C;
    do_case("t1_mode0", 1'b0, 1'b0, 1'b0, 1, 1);

    // Modes 1..3, LSB first.
    for (int m = 1; m < 4; m++) begin
      m_feed[0] = 8'h81; m_out[0] = 8'h0F;
      do_case($sformatf("t2_mode%0d", m), m[1], m[0], 1'b1, 1, 1);
    end

    // Back-to-back bytes, consumer stalled.
    m_feed[0] = 8'h11; m_feed[1] = 8'h22; m_out[0] = 8'h5A; m_out[1] = 8'hC3;
    do_case("t3_b2b_m0", 1'b0, 1'b0, 1'b0, 2, 2);
    do_case("t3_b2b_m3", 1'b1, 1'b1, 1'b0, 2, 2);

    // Empty buffer at frame start.
    m_out[0] = 8'h96;
    do_case("t4_underrun", 1'b0, 1'b0, 1'b0, 1, 0);

    // Abort after 5 bits, then a clean frame.
    set_mode(1'b0, 1'b1, 1'b0);
    m_out[0] = 8'hF0; feed_q.push_back(8'h77);
    tick(4);
    a0 = n_abt;
    frame(5, -1);
    chk("t5.abort", n_abt - a0, 1);
    chk("t5.rx_valid", 32'(rx_valid_o), 0);
    chk("t5.busy", 32'(busy_o), 0);
    m_feed[0] = 8'h3E; m_out[0] = 8'hB7;
    do_case("t5_after", 1'b0, 1'b1, 1'b0, 1, 1);

    // Reset mid-frame, then a clean frame.
    set_mode(1'b1, 1'b0, 1'b1);
    m_out[0] = 8'hE1; feed_q.push_back(8'h42);
    tick(4);
    frame(8, 4);
    m_feed[0] = 8'h6D; m_out[0] = 8'h29;
    do_case("t6_after", 1'b1, 1'b0, 1'b1, 1, 1);

    // Random frames.
    for (int r = 0; r < 8; r++) begin
      nb = $urandom_range(1, 3);
      av = $urandom_range(0, nb);
      for (int i = 0; i < 4; i++) begin
        m_feed[i] = 8'($urandom);
        m_out[i]  = 8'($urandom);
      end
      do_case($sformatf("rand%0d", r), 1'($urandom), 1'($urandom), 1'($urandom), nb, av);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
